// File: rtl/led_breath_ctrl.sv
// led_breath_ctrl: prescaled PWM "breathing" LED sequencer with four display modes.
//
// A prescaler produces one step tick every PRESCALE cycles. On each tick the
// brightness FSM ramps the duty from 0 up to full scale, holds for HOLD_TICKS
// ticks, ramps back down to 0 and counts one completed breath. A free-running
// PWM counter compared against the effective duty gives the on/off pattern that
// the display mode maps onto the four LEDs. Every output is a flop.
//
// Build option:
//   LED_BREATH_GAMMA_EN  When defined, the effective duty is (duty*duty) >> PWM_W,
//                        registered, for a perceptually smoother fade. This adds
//                        one cycle of duty-to-PWM latency. The FSM, tick and
//                        breath counter timing are the same in both builds.
//                        When undefined, the effective duty is the linear duty.

module led_breath_ctrl #(
  parameter int PRESCALE   = 1000,  // clock cycles per step tick, >= 2
  parameter int PWM_W      = 8,     // PWM counter / duty register width
  parameter int HOLD_TICKS = 64     // ticks held at full brightness, >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  output logic [3:0] led,
  output logic [3:0] breath_cnt
);

  // ---------------------------------------------------------------------------
  // Derived widths and constants
  // ---------------------------------------------------------------------------
  localparam int PW = $clog2(PRESCALE);
  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [PW-1:0]    PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE   = PW'(1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0]    HOLD_ONE  = HW'(1);
  localparam logic [PWM_W-1:0] DUTY_MAX  = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] DUTY_ONE  = PWM_W'(1);
  localparam logic [3:0]       BC_ONE    = 4'd1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_ALL_PWM = 2'd0,
    MODE_CHASE   = 2'd1,
    MODE_COUNT   = 2'd2,
    MODE_ALL_ON  = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [PW-1:0]    pre_q;
  logic [PWM_W-1:0] pwm_q;
  logic [PWM_W-1:0] duty_q;
  logic [HW-1:0]    hold_cnt_q;
  logic [3:0]       breath_cnt_q;
  logic [3:0]       led_q;
  logic [3:0]       led_d;

  logic             tick;
  logic [PWM_W-1:0] eff_duty;
  logic             pwm_on;
  logic [PWM_W-1:0] duty_up;
  logic [PWM_W-1:0] duty_dn;

  // The prescaler only runs once the sequencer has left IDLE, so the first tick
  // after enabling lands exactly PRESCALE cycles after RAMP_UP entry.
  assign tick    = (state_q != ST_IDLE) && (pre_q == PRE_LAST);
  assign duty_up = duty_q + DUTY_ONE;
  assign duty_dn = duty_q - DUTY_ONE;

  // Prescaler and PWM counter: both cleared while disabled.
  // NOTE: every clocked process assigns with <= so all flops sample the same
  // pre-edge values; a blocking = here would let later reads see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      pwm_q <= '0;
    end else if (!en) begin
      pre_q <= '0;
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + DUTY_ONE;
      if (state_q == ST_IDLE || tick) begin
        pre_q <= '0;
      end else begin
        pre_q <= pre_q + PRE_ONE;
      end
    end
  end

  // Brightness FSM: duty ramp, hold counter and breath counter advance on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      duty_q       <= '0;
      hold_cnt_q   <= '0;
      breath_cnt_q <= '0;
    end else if (!en) begin
      // Disable wins over a coincident tick; the breath count is kept.
      state_q    <= ST_IDLE;
      duty_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_RAMP_UP;
          duty_q     <= '0;
          hold_cnt_q <= '0;
        end
        ST_RAMP_UP: begin
          if (tick) begin
            duty_q <= duty_up;
            if (duty_up == DUTY_MAX) begin
              state_q    <= ST_HOLD;
              hold_cnt_q <= '0;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q <= ST_RAMP_DOWN;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_ONE;
            end
          end
        end
        ST_RAMP_DOWN: begin
          if (tick) begin
            duty_q <= duty_dn;
            if (duty_dn == '0) begin
              state_q      <= ST_RAMP_UP;
              breath_cnt_q <= breath_cnt_q + BC_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Effective duty: linear, or squared for a gamma-corrected fade
  // ---------------------------------------------------------------------------
`ifdef LED_BREATH_GAMMA_EN
  logic [2*PWM_W-1:0] duty_sq;
  logic [PWM_W-1:0]   eff_duty_q;

  assign duty_sq = {{PWM_W{1'b0}}, duty_q} * {{PWM_W{1'b0}}, duty_q};

  // Squared duty is registered; cleared while disabled so a quick re-enable
  // cannot flash a stale brightness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eff_duty_q <= '0;
    end else if (!en) begin
      eff_duty_q <= '0;
    end else begin
      eff_duty_q <= PWM_W'(duty_sq >> PWM_W);
    end
  end

  assign eff_duty = eff_duty_q;
`else
  assign eff_duty = duty_q;
`endif

  // Duty 0 is always off; full-scale duty is on for MAX of every 2^PWM_W cycles.
  assign pwm_on = (pwm_q < eff_duty);

  // Next LED pattern for the selected display mode.
  // NOTE: led_d gets a default before the case so every path assigns it and no
  // latch is inferred.
  always_comb begin
    led_d = '0;
    case (mode_e'(mode))
      MODE_ALL_PWM: led_d = {4{pwm_on}};
      MODE_CHASE:   led_d[breath_cnt_q[1:0]] = pwm_on;
      MODE_COUNT:   led_d = breath_cnt_q;
      MODE_ALL_ON:  led_d = 4'b1111;
      default:      led_d = '0;
    endcase
  end

  // LED output register: one cycle behind pwm/duty/mode/breath count, dark when disabled.
  // NOTE: the asynchronous reset clears only control flops; there is no memory
  // array in this block that would need (or should get) a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else if (!en) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

  assign led        = led_q;
  assign breath_cnt = breath_cnt_q;

endmodule

// File: doc/led_breath_ctrl.md
# led_breath_ctrl

Downstream LED driver for the SoC clock test designs. It consumes one clocked domain, for example a buffered SoC fabric clock and its reset. It replaces raw counter-bit LED taps with a prescaled, PWM-based "breathing" brightness sequencer that has four selectable display modes. It is a single-clock block, and all outputs are registered.

## Interface
- `PRESCALE`, default 1000: clock cycles per step tick; legal range ≥ 2.
- `PWM_W`, default 8: width of the PWM counter and the duty register. MAX = 2^PWM_W − 1.
- `HOLD_TICKS`, default 64: ticks spent at full brightness; legal range ≥ 1.
- `clk`, input, 1 bit: fabric clock.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `en`, input, 1 bit: sequencer enable, level-sensitive.
- `mode`, input, 2 bits: display mode select.
- `led`, output, 4 bits: registered LED drive.
- `breath_cnt`, output, 4 bits: count of completed breaths, wraps at 16.

## Operation
- Prescaler `pre` counts 0..PRESCALE−1 and wraps. `tick` is asserted in the cycle where `pre == PRESCALE−1`.
- PWM counter `pwm` (PWM_W bits) free-runs every cycle while `en` is high and wraps at MAX→0.
- `pwm_on = (pwm < eff_duty)`.
  - duty 0 → always off.
  - duty MAX → on for MAX of every 2^PWM_W cycles.
- FSM states are IDLE, RAMP_UP, HOLD and RAMP_DOWN. All state updates other than leaving IDLE happen only on `tick`:
  - IDLE: duty = 0. While `en` = 1, go to RAMP_UP on the next clock.
  - RAMP_UP: duty ← duty + 1. If the new duty == MAX, go to HOLD with `hold_cnt` = 0.
  - HOLD: `hold_cnt` ← `hold_cnt` + 1. When `hold_cnt == HOLD_TICKS−1`, go to RAMP_DOWN.
  - RAMP_DOWN: duty ← duty − 1. If the new duty == 0, go to RAMP_UP and increment `breath_cnt` (mod 16).
- One breath is 2·MAX + HOLD_TICKS ticks. Duty never over- or underflows.
- `en` = 0 in any state has the following effect on the next clock:
  - FSM goes to IDLE.
  - duty, `pre`, `pwm` and `hold_cnt` are cleared to 0.
  - `led` = 0.
  - `breath_cnt` holds its value.
- Display modes (led register next value):
  - 0: all four bits = `pwm_on`.
  - 1: chase. One-hot bit `breath_cnt[1:0]` = `pwm_on`; the other bits are 0.
  - 2: `breath_cnt[3:0]`, static with no PWM.
  - 3: 4'b1111.
- A `mode` change takes effect on the next clock and does not disturb the FSM, duty, prescaler or `breath_cnt`.

## Timing
- Reset (`rst_n` low, asynchronous) drives `led` = 0, `breath_cnt` = 0, FSM = IDLE and all counters to 0. This happens immediately and holds while low. Release is sampled on `clk`.
- Reset asserted mid-breath behaves identically: there is no partial-state retention.
- `en` rising edge at clock N puts the FSM in RAMP_UP from clock N+1. `pre` starts at 0 on N+1. The first tick occurs PRESCALE cycles later.
- `led` has 1-cycle latency from `pwm`/duty/`mode`/`breath_cnt` to the output.
- `tick` coinciding with `en` falling: the disable wins and no duty update is applied.
- `breath_cnt` increments in the same clock that duty reaches 0. Mode 1/2 outputs reflect the change one cycle later.

## Configuration
- `LED_BREATH_GAMMA_EN` defined: `eff_duty = (duty*duty) >> PWM_W`, computed with a 2·PWM_W-bit product and registered. This adds 1 cycle of duty-to-`pwm_on` latency.
- `LED_BREATH_GAMMA_EN` undefined: `eff_duty = duty`, linear, with no added latency.
- The FSM, tick and `breath_cnt` timing are identical in both builds.

## Test plan
All scenarios use PRESCALE=4, PWM_W=4, HOLD_TICKS=2.
- Reset: run 50 cycles with en=1 and mode=0, then pulse `rst_n` low between clock edges → `led` = 0 and `breath_cnt` = 0 immediately. After release with en=1, the first tick comes 4 cycles after RAMP_UP entry.
- Full breath, mode 2: raise en → duty 0→15 over 15 ticks, HOLD 2 ticks, then 15→0. `breath_cnt` goes 0→1 exactly 128 cycles after RAMP_UP entry, and `led` = 4'b0001 one cycle later.
- PWM duty, mode 0: freeze observation while duty = 8 (linear build) → `led` = 4'b1111 for 8 of every 16 cycles. With `LED_BREATH_GAMMA_EN`, `led` = 4'b1111 for 4 of every 16 cycles.
- Chase, mode 1: after 5 breaths → `breath_cnt` = 5, and only `led[1]` toggles with PWM. After 16 breaths `breath_cnt` wraps to 0.
- Disable mid-HOLD: drop en during HOLD → next clock `led` = 0, duty = 0, FSM IDLE, `breath_cnt` unchanged. Re-raising en restarts from duty 0.
- Mode switch: change mode from 0→3 mid-RAMP_DOWN → `led` = 4'b1111 one cycle later. The duty trajectory is unchanged versus an undisturbed run.
